microwave_timer_ctrl: RTL and testbench
=======================================

Name: microwave_timer_ctrl

Overview:
Controller that sequences the microwave cook timer, a cascaded BCD counter chain of mod-10 and mod-6 stages. It collects keypad digits and loads them into the counters. It then paces the countdown with a 1 Hz enable, gates the magnetron, and handles the pause, resume and clear actions driven by the door and the start/stop keys. It sits between the keypad/door inputs and the timer counter chain.

Parameters:
TICK_DIV, 100, clock cycles per one-second countdown tick (minimum 2)
BEEP_SECS, 3, ticks spent in DONE with beep asserted

Ports:
clock  in  1  system clock, rising edge
clrn  in  1  asynchronous active-low reset
key_valid  in  1  one-cycle pulse, key_data holds a digit
key_data  in  4  BCD digit; values above 9 are ignored
start  in  1  one-cycle start pulse
stop  in  1  one-cycle stop/clear pulse
door_closed  in  1  level, 1 = door shut
timer_zero  in  1  counter chain reads 0:00
load_data  out  12  {minutes, sec_tens, sec_ones} BCD presented to the counters
cnt_loadn  out  1  active-low, one-cycle parallel load to the counters
cnt_enable  out  1  one-cycle countdown enable per tick
cnt_clrn  out  1  active-low, one-cycle clear to the counters
mag_on  out  1  magnetron drive
beep  out  1  completion buzzer
state  out  3  current FSM state, for display and debug

Behaviour:
- Reset (clrn low, asynchronous): state=IDLE; entry register=0; load_data=0; cnt_loadn=1; cnt_clrn=1; cnt_enable=0; mag_on=0; beep=0; prescaler=0.
- All outputs are registered. Every state change takes effect on the clock edge after the qualifying input.
- State encoding: IDLE=0, ENTRY=1, LOAD=2, COOK=3, PAUSE=4, DONE=5.
- Digit entry, accepted only in IDLE and ENTRY:
  - A valid digit (key_data ≤ 9) updates entry <= {entry[7:0], key_data} and moves the FSM to ENTRY.
  - A fourth digit shifts the oldest digit out.
  - key_valid is ignored in every other state and for digits above 9.
- load_data always equals the entry register.
- Input priority when inputs coincide: stop > door open > start > key_valid.
- IDLE: start is ignored; stop is a no-op.
- ENTRY:
  - stop clears entry and goes to IDLE.
  - start goes to LOAD only if door_closed=1, entry≠0 and sec_tens≤5. Otherwise start is rejected and the FSM stays in ENTRY.
- LOAD: lasts exactly one cycle with cnt_loadn=0, then goes to COOK. The prescaler clears on entry to COOK.
- COOK:
  - mag_on=1.
  - The prescaler counts 0..TICK_DIV-1. cnt_enable pulses for one cycle when the count wraps, so the first pulse occurs TICK_DIV cycles after COOK is entered.
  - timer_zero=1 goes to DONE. timer_zero is evaluated only from the second cycle of COOK onward.
  - stop, or door_closed=0, goes to PAUSE.
- PAUSE:
  - mag_on=0, no cnt_enable, prescaler held.
  - start with door_closed=1 goes to COOK with the prescaler cleared, so the partial second is discarded.
  - stop drives cnt_clrn=0 for one cycle, clears entry and goes to IDLE.
- DONE:
  - mag_on=0, beep=1, entry cleared on entry to DONE.
  - Leaves for IDLE after BEEP_SECS prescaler wraps; beep falls in the same cycle.
  - stop goes to IDLE immediately.
  - start and key_valid are ignored.
- Prescaler width is clog2(TICK_DIV). Its terminal count is TICK_DIV-1, with no off-by-one.

Decomposition:
- Shared package microwave_pkg holds:
  - the state encodings;
  - BCD_W=4 and DIGITS=3;
  - the SEC_TENS_MAX=5 constant.
- One sub-module, tick_prescaler: mod-TICK_DIV counter with synchronous clear and hold inputs, producing a one-cycle tick. It is reused for cook pacing and the beep duration.

Test Plan:
(All scenarios use TICK_DIV=4 and BEEP_SECS=3.)
1. Reset: assert clrn=0 mid-COOK -> all outputs immediately at reset values, state=0; release -> remains IDLE.
2. Keys 1,3,0, then start with door closed -> load_data=12'h130; one cycle with cnt_loadn=0; state=3; mag_on=1; cnt_enable pulses every 4th cycle, first pulse 4 cycles after COOK entry.
3. Keys 0,0,5, start; bench model drives timer_zero after 5 enables -> DONE next cycle; beep=1 for 12 cycles; then IDLE with entry=0.
4. Door opened during COOK -> PAUSE next cycle, mag_on=0, no enables; close door, then start -> COOK, next enable 4 cycles later.
5. stop in COOK, then stop again -> PAUSE, then one-cycle cnt_clrn=0, state=IDLE, load_data=0.
6. Keys 0,7,0, then start -> rejected (stays ENTRY, cnt_loadn stays 1); key_data=11 ignored; start and stop in the same cycle in ENTRY -> IDLE.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared state encodings and BCD digit geometry for the microwave cook-timer controller.
package microwave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_LOAD  = 3'd2,
        ST_COOK  = 3'd3,
        ST_PAUSE = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam int BCD_W   = 4;
    localparam int DIGITS  = 3;
    localparam int ENTRY_W = BCD_W * DIGITS;

    localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [BCD_W-1:0] BCD_MAX      = 4'd9;

    function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
        return digit <= BCD_MAX;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Mod-TICK_DIV counter with synchronous clear and hold; o_tick marks the wrap cycle.
module tick_prescaler #(
    parameter int TICK_DIV = 100
) (
    input  logic clock,
    input  logic clrn,
    input  logic i_clear,
    input  logic i_hold,
    output logic o_tick
);

    localparam int               CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_wrap;

    assign w_wrap = (r_count == TERM);
    // Clear is deliberately left out of o_tick so the parent's next-state logic can drive it without a loop.
    assign o_tick = w_wrap && !i_hold;

    // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (!i_hold) begin
            r_count <= w_wrap ? '0 : r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Sequences keypad entry, counter load, 1 Hz countdown pacing, pause/resume and the completion beep.
module microwave_timer_ctrl
    import microwave_pkg::*;
#(
    parameter int TICK_DIV  = 100,
    parameter int BEEP_SECS = 3
) (
    input  logic               clock,
    input  logic               clrn,
    input  logic               key_valid,
    input  logic [BCD_W-1:0]   key_data,
    input  logic               start,
    input  logic               stop,
    input  logic               door_closed,
    input  logic               timer_zero,
    output logic [ENTRY_W-1:0] load_data,
    output logic               cnt_loadn,
    output logic               cnt_enable,
    output logic               cnt_clrn,
    output logic               mag_on,
    output logic               beep,
    output logic [2:0]         state
);

    localparam int               BEEP_W    = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_SECS - 1);

    state_e             r_state;
    logic [ENTRY_W-1:0] r_entry;
    logic               r_cnt_loadn;
    logic               r_cnt_enable;
    logic               r_cnt_clrn;
    logic               r_mag_on;
    logic               r_beep;
    logic               r_cook_first;
    logic [BEEP_W-1:0]  r_beep_cnt;

    state_e             w_next_state;
    logic [ENTRY_W-1:0] w_next_entry;
    logic [ENTRY_W-1:0] w_shift_entry;
    logic               w_key_ok;
    logic               w_start_ok;
    logic               w_clr_chain;
    logic               w_enter_cook;
    logic               w_enter_done;
    logic               w_tick;

    assign w_key_ok      = key_valid && is_bcd(key_data);
    assign w_shift_entry = {r_entry[ENTRY_W-BCD_W-1:0], key_data};
    assign w_start_ok    = door_closed && (r_entry != '0) &&
                           (r_entry[2*BCD_W-1:BCD_W] <= SEC_TENS_MAX);
    assign w_enter_cook  = (w_next_state == ST_COOK) && (r_state != ST_COOK);
    assign w_enter_done  = (w_next_state == ST_DONE) && (r_state != ST_DONE);

    // One prescaler paces both the cook seconds and the beep seconds; a fresh second starts on each entry.
    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock   (clock),
        .clrn    (clrn),
        .i_clear (w_enter_cook || w_enter_done),
        .i_hold  (!((r_state == ST_COOK) || (r_state == ST_DONE))),
        .o_tick  (w_tick)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_entry = r_entry;
        w_clr_chain  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!stop && w_key_ok) begin
                    w_next_entry = w_shift_entry;
                    w_next_state = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (stop) begin
                    w_next_entry = '0;
                    w_next_state = ST_IDLE;
                end else if (start) begin
                    if (w_start_ok) w_next_state = ST_LOAD;
                end else if (w_key_ok) begin
                    w_next_entry = w_shift_entry;
                end
            end
            ST_LOAD: w_next_state = ST_COOK;
            ST_COOK: begin
                // The chain was loaded on the edge entering COOK; its zero flag is trusted one cycle later.
                if (stop || !door_closed) begin
                    w_next_state = ST_PAUSE;
                end else if (timer_zero && !r_cook_first) begin
                    w_next_entry = '0;
                    w_next_state = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    w_clr_chain  = 1'b1;
                    w_next_entry = '0;
                    w_next_state = ST_IDLE;
                end else if (start && door_closed) begin
                    w_next_state = ST_COOK;
                end
            end
            ST_DONE: begin
                if (stop || (w_tick && (r_beep_cnt == BEEP_LAST))) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            r_state      <= ST_IDLE;
            r_entry      <= '0;
            r_cnt_loadn  <= 1'b1;
            r_cnt_enable <= 1'b0;
            r_cnt_clrn   <= 1'b1;
            r_mag_on     <= 1'b0;
            r_beep       <= 1'b0;
            r_cook_first <= 1'b0;
            r_beep_cnt   <= '0;
        end else begin
            r_state      <= w_next_state;
            r_entry      <= w_next_entry;
            r_cnt_loadn  <= (w_next_state != ST_LOAD);
            r_cnt_enable <= w_tick && (r_state == ST_COOK) && (w_next_state == ST_COOK);
            r_cnt_clrn   <= !w_clr_chain;
            r_mag_on     <= (w_next_state == ST_COOK);
            r_beep       <= (w_next_state == ST_DONE);
            r_cook_first <= w_enter_cook;
            if (w_enter_done) begin
                r_beep_cnt <= '0;
            end else if ((r_state == ST_DONE) && w_tick) begin
                r_beep_cnt <= r_beep_cnt + BEEP_W'(1);
            end
        end
    end

    assign load_data  = r_entry;
    assign cnt_loadn  = r_cnt_loadn;
    assign cnt_enable = r_cnt_enable;
    assign cnt_clrn   = r_cnt_clrn;
    assign mag_on     = r_mag_on;
    assign beep       = r_beep;
    assign state      = r_state;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Bench for microwave_timer_ctrl: directed scenarios plus random keypad/door traffic against a cycle-count model.
module tb_microwave_timer_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int BEEP_SECS = 3;
    localparam int S_IDLE = 0, S_ENTRY = 1, S_LOAD = 2, S_COOK = 3, S_PAUSE = 4, S_DONE = 5;

    logic        clock = 1'b0;
    logic        clrn = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_data = 4'd0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        door_closed = 1'b1;
    logic        timer_zero = 1'b1;
    logic [11:0] load_data;
    logic        cnt_loadn, cnt_enable, cnt_clrn, mag_on, beep;
    logic [2:0]  state;

    int n_tests = 0;
    int n_fail = 0;

    // Environment: the counter chain, held as a plain count of seconds.
    int chain_secs = 0;
    logic        p_loadn, p_en, p_clrn;
    logic [11:0] p_data;

    // Reference model: cycle counts since entering COOK / DONE instead of a prescaler.
    int   m_state, m_entry, m_cook_n, m_done_n;
    logic m_clr, m_en;

    microwave_timer_ctrl #(.TICK_DIV(TICK_DIV), .BEEP_SECS(BEEP_SECS)) dut (
        .clock(clock), .clrn(clrn), .key_valid(key_valid), .key_data(key_data),
        .start(start), .stop(stop), .door_closed(door_closed), .timer_zero(timer_zero),
        .load_data(load_data), .cnt_loadn(cnt_loadn), .cnt_enable(cnt_enable),
        .cnt_clrn(cnt_clrn), .mag_on(mag_on), .beep(beep), .state(state)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_entry = 0; m_cook_n = 0; m_done_n = 0;
        m_clr = 1'b0; m_en = 1'b0;
    endtask

    task automatic model_step(input logic kv, input logic [3:0] kd, input logic st,
                              input logic sp, input logic door, input logic tz);
        int   nxt;
        logic key_ok;
        int   tens;
        nxt    = m_state;
        m_clr  = 1'b0;
        key_ok = kv && (kd <= 4'd9);
        tens   = (m_entry / 16) % 16;
        case (m_state)
            S_IDLE: if (!sp && key_ok) begin
                m_entry = (m_entry * 16 + int'(kd)) % 4096;
                nxt = S_ENTRY;
            end
            S_ENTRY: begin
                if (sp) begin m_entry = 0; nxt = S_IDLE; end
                else if (st) begin
                    if (door && m_entry != 0 && tens <= 5) nxt = S_LOAD;
                end else if (key_ok) m_entry = (m_entry * 16 + int'(kd)) % 4096;
            end
            S_LOAD: begin nxt = S_COOK; m_cook_n = 1; end
            S_COOK: begin
                if (sp || !door) nxt = S_PAUSE;
                else if (m_cook_n > 1 && tz) begin nxt = S_DONE; m_entry = 0; m_done_n = 1; end
                else m_cook_n = m_cook_n + 1;
            end
            S_PAUSE: begin
                if (sp) begin nxt = S_IDLE; m_entry = 0; m_clr = 1'b1; end
                else if (st && door) begin nxt = S_COOK; m_cook_n = 1; end
            end
            S_DONE: begin
                if (sp || m_done_n == BEEP_SECS * TICK_DIV) nxt = S_IDLE;
                else m_done_n = m_done_n + 1;
            end
            default: nxt = S_IDLE;
        endcase
        // An enable lands on every TICK_DIV-th COOK cycle after the first.
        m_en    = (m_state == S_COOK) && (nxt == S_COOK) && ((m_cook_n - 1) % TICK_DIV == 0);
        m_state = nxt;
    endtask

    task automatic check_all(input string ph);
        check({ph, "_state"}, 32'(state), 32'(m_state));
        check({ph, "_load_data"}, 32'(load_data), 32'(m_entry));
        check({ph, "_cnt_loadn"}, 32'(cnt_loadn), 32'(m_state != S_LOAD));
        check({ph, "_cnt_enable"}, 32'(cnt_enable), 32'(m_en));
        check({ph, "_cnt_clrn"}, 32'(cnt_clrn), 32'(!m_clr));
        check({ph, "_mag_on"}, 32'(mag_on), 32'(m_state == S_COOK));
        check({ph, "_beep"}, 32'(beep), 32'(m_state == S_DONE));
    endtask

    task automatic check_reset(input string ph);
        check({ph, "_rst_state"}, 32'(state), 32'd0);
        check({ph, "_rst_load_data"}, 32'(load_data), 32'd0);
        check({ph, "_rst_outs"}, 32'({cnt_loadn, cnt_enable, cnt_clrn, mag_on, beep}), 32'b10100);
    endtask

    task automatic run_cycle(input string ph, input logic kv, input logic [3:0] kd,
                             input logic st, input logic sp);
        @(negedge clock);
        key_valid = kv; key_data = kd; start = st; stop = sp;
        p_loadn = cnt_loadn; p_en = cnt_enable; p_clrn = cnt_clrn; p_data = load_data;
        model_step(kv, kd, st, sp, door_closed, timer_zero);
        @(posedge clock);
        #1;
        if (!p_clrn) chain_secs = 0;
        else if (!p_loadn) chain_secs = int'(p_data[11:8]) * 60 + int'(p_data[7:4]) * 10 + int'(p_data[3:0]);
        else if (p_en && chain_secs > 0) chain_secs = chain_secs - 1;
        timer_zero = (chain_secs == 0);
        check_all(ph);
    endtask

    task automatic press(input string ph, input logic [3:0] d);
        run_cycle(ph, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic idle(input string ph);
        run_cycle(ph, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic first_enable_after(input string ph);
        int first;
        first = 0;
        for (int i = 1; i <= TICK_DIV + 2; i++) begin
            idle(ph);
            if (cnt_enable && first == 0) first = i;
        end
        check({ph, "_first_enable"}, 32'(first), 32'(TICK_DIV));
    endtask

    initial begin
        int n_en;
        int n_beep;
        int unsigned r;
        logic [3:0] kd;

        model_reset();
        #2 clrn = 1'b0;
        #1 check_reset("por");
        @(negedge clock);
        clrn = 1'b1;

        // Keys 1,3,0 then start: one load cycle, then COOK with paced enables.
        press("t2", 4'd1); press("t2", 4'd3); press("t2", 4'd0);
        check("t2_entry", 32'(load_data), 32'h130);
        run_cycle("t2", 1'b0, 4'd0, 1'b1, 1'b0);
        check("t2_load_pulse", 32'({state, cnt_loadn}), 32'({3'd2, 1'b0}));
        idle("t2");
        check("t2_cook", 32'({state, mag_on}), 32'({3'd3, 1'b1}));
        first_enable_after("t2");

        // Asynchronous reset in the middle of COOK.
        #2 clrn = 1'b0;
        #1 check_reset("t1");
        model_reset();
        @(negedge clock);
        @(negedge clock);
        clrn = 1'b1;
        for (int i = 0; i < 3; i++) idle("t1");
        check("t1_idle", 32'(state), 32'd0);

        // 0:05 runs to zero, beeps for BEEP_SECS seconds, returns to IDLE.
        press("t3", 4'd0); press("t3", 4'd0); press("t3", 4'd5);
        run_cycle("t3", 1'b0, 4'd0, 1'b1, 1'b0);
        n_en = 0;
        for (int i = 0; i < 100 && state != 3'd5; i++) begin
            idle("t3");
            if (cnt_enable) n_en++;
        end
        check("t3_reached_done", 32'(state), 32'd5);
        check("t3_enables", 32'(n_en), 32'd5);
        n_beep = beep ? 1 : 0;
        for (int i = 0; i < 50 && state != 3'd0; i++) begin
            idle("t3");
            if (beep) n_beep++;
        end
        check("t3_beep_cycles", 32'(n_beep), 32'(BEEP_SECS * TICK_DIV));
        check("t3_idle_entry", 32'({state, load_data}), 32'd0);

        // Door opens mid-cook: PAUSE, no enables; resume restarts the second.
        press("t4", 4'd2); press("t4", 4'd0);
        run_cycle("t4", 1'b0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) idle("t4");
        door_closed = 1'b0;
        idle("t4");
        check("t4_pause", 32'({state, mag_on}), 32'({3'd4, 1'b0}));
        n_en = 0;
        for (int i = 0; i < 8; i++) begin
            idle("t4");
            if (cnt_enable) n_en++;
        end
        check("t4_no_enables", 32'(n_en), 32'd0);
        door_closed = 1'b1;
        idle("t4");
        run_cycle("t4", 1'b0, 4'd0, 1'b1, 1'b0);
        check("t4_resume", 32'(state), 32'd3);
        first_enable_after("t4");

        // Stop in COOK pauses, second stop clears the chain and the entry.
        run_cycle("t5", 1'b0, 4'd0, 1'b0, 1'b1);
        check("t5_pause", 32'(state), 32'd4);
        run_cycle("t5", 1'b0, 4'd0, 1'b0, 1'b1);
        check("t5_clear", 32'({state, load_data, cnt_clrn}), 32'({3'd0, 12'h000, 1'b0}));
        idle("t5");
        check("t5_clrn_released", 32'(cnt_clrn), 32'd1);

        // Start rejections, ignored digit, stop beating start.
        press("t6", 4'd0); press("t6", 4'd7); press("t6", 4'd0);
        run_cycle("t6", 1'b0, 4'd0, 1'b1, 1'b0);
        check("t6_rejected", 32'({state, cnt_loadn}), 32'({3'd1, 1'b1}));
        press("t6", 4'd11);
        check("t6_bad_digit", 32'(load_data), 32'h070);
        run_cycle("t6", 1'b0, 4'd0, 1'b1, 1'b1);
        check("t6_stop_wins", 32'(state), 32'd0);
        press("t6", 4'd0);
        run_cycle("t6", 1'b0, 4'd0, 1'b1, 1'b0);
        check("t6_zero_rejected", 32'(state), 32'd1);
        press("t6", 4'd5); press("t6", 4'd9);
        run_cycle("t6", 1'b0, 4'd0, 1'b1, 1'b0);
        check("t6_tens5_accepted", 32'(state), 32'd2);
        run_cycle("t6", 1'b0, 4'd0, 1'b0, 1'b1);
        run_cycle("t6", 1'b0, 4'd0, 1'b0, 1'b1);
        run_cycle("t6", 1'b0, 4'd0, 1'b0, 1'b1);
        check("t6_back_idle", 32'(state), 32'd0);

        // Random keypad, start/stop and door traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 31) == 0) door_closed = ~door_closed;
            r  = $urandom_range(0, 63);
            kd = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 11));
            if (r < 12)       run_cycle("rnd", 1'b1, kd, 1'b0, 1'b0);
            else if (r < 16)  run_cycle("rnd", 1'b0, 4'd0, 1'b1, 1'b0);
            else if (r == 16) run_cycle("rnd", 1'b0, 4'd0, 1'b0, 1'b1);
            else              idle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
